resp_checker: RTL and testbench

Response-side counterpart of the stimulus driver used in equivalence runs. It samples the 99-bit output bus `y` of a reference netlist and a synthesized netlist once per accepted sample. For each sample it compares the two buses under a bit mask, counts mismatches and latches the first failure. It also compacts the DUT responses into a MISR signature. It sits beside `top` instances in simulation/equivalence benches and produces a single pass/fail verdict after `N_VEC` samples.

---
 rtl/resp_chk_pkg.sv | 12 +
 rtl/misr_reg.sv | 29 ++
 rtl/resp_checker.sv | 111 +++++++++++
 tb/tb_resp_checker.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/resp_chk_pkg.sv
// rtl/resp_chk_pkg.sv - shared types and defaults for the response checker
package resp_chk_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} chk_state_t;

  localparam int             DEF_WIDTH = 99;
  localparam int             DEF_CNT_W = 16;
  localparam logic [98:0]    DEF_POLY  = 99'h41;
  localparam logic [98:0]    DEF_SEED  = 99'h0;
  localparam logic [15:0]    FAIL_IDX_NONE = 16'hFFFF;

endpackage

// File: rtl/misr_reg.sv
// rtl/misr_reg.sv - multiple-input signature register compacting one word per enabled cycle
module misr_reg #(
  parameter int               WIDTH = 99,
  parameter logic [WIDTH-1:0] POLY  = '0,
  parameter logic [WIDTH-1:0] SEED  = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] sig
);

  logic [WIDTH-1:0] r_sig;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig <= SEED;
    end else if (clear) begin
      r_sig <= SEED;
    end else if (en) begin
      r_sig <= {r_sig[WIDTH-2:0], 1'b0} ^ (r_sig[WIDTH-1] ? POLY : '0) ^ data;
    end
  end

  assign sig = r_sig;

endmodule

// File: rtl/resp_checker.sv
// rtl/resp_checker.sv - masked ref/dut output comparison with first-fail latch and MISR
module resp_checker
  import resp_chk_pkg::*;
#(
  parameter int               WIDTH = DEF_WIDTH,
  parameter int               N_VEC = 20,
  parameter int               CNT_W = DEF_CNT_W,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(DEF_POLY),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEF_SEED)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] y_ref,
  input  logic [WIDTH-1:0] y_dut,
  input  logic [WIDTH-1:0] mask,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [WIDTH-1:0] first_fail_diff,
  output logic [WIDTH-1:0] signature
);

  localparam logic [CNT_W-1:0] IDX_NONE = '1;

  chk_state_t       r_state, w_state_next;
  logic             r_busy, r_done, r_pass;
  logic [CNT_W-1:0] r_sample_cnt, r_mismatch_cnt, r_first_idx;
  logic [WIDTH-1:0] r_first_diff;
  logic [WIDTH-1:0] w_diff;
  logic             w_miss, w_accept, w_last;
  logic [CNT_W-1:0] w_mis_next;

  // start wins over a coincident sample, so that sample is never accepted
  assign w_accept = (r_state == RUN) && sample_valid && !start;
  assign w_diff   = (y_ref ^ y_dut) & mask;
  assign w_miss   = |w_diff;
  assign w_last   = (r_sample_cnt == CNT_W'(N_VEC - 1));
  assign w_mis_next = (w_accept && w_miss && (r_mismatch_cnt != '1))
                      ? r_mismatch_cnt + CNT_W'(1) : r_mismatch_cnt;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = RUN;
      RUN: begin
        if (start)                  w_state_next = RUN;
        else if (w_accept && w_last) w_state_next = DONE;
      end
      DONE:    if (start) w_state_next = RUN;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next == RUN);
      r_done  <= (w_state_next == DONE);
      r_pass  <= (w_state_next == DONE) && (w_mis_next == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sample_cnt   <= '0;
      r_mismatch_cnt <= '0;
      r_first_idx    <= IDX_NONE;
      r_first_diff   <= '0;
    end else if (start) begin
      r_sample_cnt   <= '0;
      r_mismatch_cnt <= '0;
      r_first_idx    <= IDX_NONE;
      r_first_diff   <= '0;
    end else if (w_accept) begin
      r_sample_cnt   <= r_sample_cnt + CNT_W'(1);
      r_mismatch_cnt <= w_mis_next;
      if (w_miss && (r_first_idx == IDX_NONE)) begin
        r_first_idx  <= r_sample_cnt;
        r_first_diff <= w_diff;
      end
    end
  end

  misr_reg #(.WIDTH(WIDTH), .POLY(POLY), .SEED(SEED)) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (start),
    .en    (w_accept),
    .data  (y_dut),
    .sig   (signature)
  );

  assign busy            = r_busy;
  assign done            = r_done;
  assign pass            = r_pass;
  assign sample_cnt      = r_sample_cnt;
  assign mismatch_cnt    = r_mismatch_cnt;
  assign first_fail_idx  = r_first_idx;
  assign first_fail_diff = r_first_diff;

endmodule

// File: tb/tb_resp_checker.sv
// tb/tb_resp_checker.sv - self-checking bench for resp_checker
module tb_resp_checker;
  import resp_chk_pkg::*;

  localparam int          W     = 99;
  localparam int          NV    = 20;
  localparam logic [98:0] ONES  = {99{1'b1}};
  localparam logic [98:0] TPOLY = 99'h41;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          sample_valid = 1'b0;
  logic [98:0]   y_ref = '0, y_dut = '0, mask = '0;
  logic          busy, done, pass;
  logic [15:0]   sample_cnt, mismatch_cnt, first_fail_idx;
  logic [98:0]   first_fail_diff, signature;

  int checks = 0;
  int errors = 0;

  resp_checker dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sample_valid(sample_valid),
    .y_ref(y_ref), .y_dut(y_dut), .mask(mask),
    .busy(busy), .done(done), .pass(pass),
    .sample_cnt(sample_cnt), .mismatch_cnt(mismatch_cnt),
    .first_fail_idx(first_fail_idx), .first_fail_diff(first_fail_diff),
    .signature(signature)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, logic [98:0] got, logic [98:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endfunction

  // Model: run phase 0=idle 1=running 2=finished, plus run-level results
  int          m_phase;
  int          m_cnt;
  int          m_mis;
  logic [15:0] m_idx;
  logic [98:0] m_diff, m_sig, t_diff;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_cnt = 0; m_mis = 0; m_idx = FAIL_IDX_NONE; m_diff = '0; m_sig = '0;
    end else if (start) begin
      m_phase = 1; m_cnt = 0; m_mis = 0; m_idx = FAIL_IDX_NONE; m_diff = '0; m_sig = '0;
    end else if (m_phase == 1 && sample_valid) begin
      t_diff = (y_ref ^ y_dut) & mask;
      if (t_diff != '0) begin
        if (m_mis < 65535) m_mis++;
        if (m_idx == FAIL_IDX_NONE) begin
          m_idx  = 16'(m_cnt);
          m_diff = t_diff;
        end
      end
      m_sig = (m_sig << 1) ^ (m_sig[98] ? TPOLY : '0) ^ y_dut;
      m_cnt++;
      if (m_cnt == NV) m_phase = 2;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("busy",            99'(busy),            99'(m_phase == 1));
      check("done",            99'(done),            99'(m_phase == 2));
      check("pass",            99'(pass),            99'(m_phase == 2 && m_mis == 0));
      check("sample_cnt",      99'(sample_cnt),      99'(m_cnt));
      check("mismatch_cnt",    99'(mismatch_cnt),    99'(m_mis));
      check("first_fail_idx",  99'(first_fail_idx),  99'(m_idx));
      check("first_fail_diff", first_fail_diff,      m_diff);
      check("signature",       signature,            m_sig);
    end
  end

  task automatic step(input logic s, input logic v, input logic [98:0] r,
                      input logic [98:0] d, input logic [98:0] m);
    @(negedge clk); #1;
    start = s; sample_valid = v; y_ref = r; y_dut = d; mask = m;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic post();
    @(posedge clk); #1;
  endtask

  function automatic logic [98:0] rnd99();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[98:0];
  endfunction

  logic [98:0] v;

  initial begin
    #1 rst_n = 1'b0;
    #1;
    check("rst_busy",  99'(busy), 99'(0));
    check("rst_done",  99'(done), 99'(0));
    check("rst_idx",   99'(first_fail_idx), 99'(16'hFFFF));
    check("rst_sig",   signature, 99'h0);
    @(negedge clk); #1 rst_n = 1'b1;

    // MISR sequence
    step(1'b1, 1'b0, '0, '0, ONES);
    step(1'b0, 1'b1, 99'h1, 99'h1, ONES); post();
    check("misr_1", signature, 99'h1);
    step(1'b0, 1'b1, 99'h0, 99'h0, ONES); post();
    check("misr_2", signature, 99'h2);
    v = 99'h1 << 98;
    step(1'b0, 1'b1, v, v, ONES); post();
    step(1'b0, 1'b1, 99'h0, 99'h0, ONES); post();
    check("misr_poly", signature, 99'h49);
    idle(); post();

    // asynchronous reset mid-run
    #2 rst_n = 1'b0;
    #1;
    check("arst_cnt",  99'(sample_cnt), 99'(0));
    check("arst_busy", 99'(busy), 99'(0));
    check("arst_sig",  signature, 99'h0);
    check("arst_idx",  99'(first_fail_idx), 99'(16'hFFFF));
    @(negedge clk); #1 rst_n = 1'b1;

    // clean pass
    step(1'b1, 1'b0, '0, '0, ONES);
    for (int i = 0; i < NV; i++) begin
      v = rnd99();
      step(1'b0, 1'b1, v, v, ONES);
    end
    post();
    check("clean_cnt",  99'(sample_cnt), 99'(20));
    check("clean_done", 99'(done), 99'(1));
    check("clean_pass", 99'(pass), 99'(1));
    idle(); post();
    check("clean_busy", 99'(busy), 99'(0));

    // sample in DONE is ignored
    step(1'b0, 1'b1, 99'h5, 99'h0, ONES); post();
    check("done_cnt", 99'(sample_cnt), 99'(20));
    check("done_mis", 99'(mismatch_cnt), 99'(0));
    idle();

    // first-fail latch
    step(1'b1, 1'b0, '0, '0, ONES);
    for (int i = 0; i < NV; i++) begin
      v = rnd99();
      if (i == 3)      step(1'b0, 1'b1, v, v ^ 99'h1, ONES);
      else if (i == 7) step(1'b0, 1'b1, v, v ^ (99'h1 << 98), ONES);
      else             step(1'b0, 1'b1, v, v, ONES);
    end
    post();
    check("ff_mis",  99'(mismatch_cnt), 99'(2));
    check("ff_idx",  99'(first_fail_idx), 99'(3));
    check("ff_diff", first_fail_diff, 99'h1);
    check("ff_done", 99'(done), 99'(1));
    check("ff_pass", 99'(pass), 99'(0));
    idle();

    // mask
    step(1'b1, 1'b0, '0, '0, ONES);
    step(1'b0, 1'b1, 99'h0, 99'h4, ~99'h4); post();
    check("mask_off", 99'(mismatch_cnt), 99'(0));
    step(1'b0, 1'b1, 99'h0, 99'h4, ONES); post();
    check("mask_on", 99'(mismatch_cnt), 99'(1));

    // start with coincident sample at index 10
    for (int i = 2; i < 10; i++) begin
      v = rnd99();
      step(1'b0, 1'b1, v, v, ONES);
    end
    step(1'b1, 1'b1, 99'h3, 99'h7, ONES); post();
    check("rs_cnt",  99'(sample_cnt), 99'(0));
    check("rs_mis",  99'(mismatch_cnt), 99'(0));
    check("rs_sig",  signature, 99'h0);
    check("rs_busy", 99'(busy), 99'(1));
    step(1'b0, 1'b1, 99'h8, 99'h8, ONES); post();
    check("rs_resume", 99'(sample_cnt), 99'(1));
    idle(); post();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
